// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizing constants and register-index type for the register file
package reg_file_pkg;

  localparam int DATA_W    = 64;
  localparam int NUM_REGS  = 32;
  localparam int ZERO_REG  = 31;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_word.sv
// rtl/reg_word.sv - one architectural register with write enable and synchronous clear
module reg_word #(
  parameter int DATA_W = reg_file_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with hard-wired zero register and write bypass
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int ZERO_REG = reg_file_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  reg_idx_t          ReadRegister1,
  input  reg_idx_t          ReadRegister2,
  input  reg_idx_t          WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  logic [DATA_W-1:0] stored [NUM_REGS];
  logic              write_ok;
  logic              bypass1;
  logic              bypass2;

  // A write is live only outside reset and never for XZR; this also gates the bypass.
  assign write_ok = RegWrite && !reset && (WriteRegister != ZERO_IDX);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    if (i == ZERO_REG) begin : g_zero
      assign stored[i] = '0;
    end else begin : g_word
      logic en;
      assign en = write_ok && (WriteRegister == reg_idx_t'(i));
      reg_word #(.DATA_W(DATA_W)) u_word (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (WriteData),
        .q     (stored[i])
      );
    end
  end

  assign bypass1 = write_ok && (WriteRegister == ReadRegister1);
  assign bypass2 = write_ok && (WriteRegister == ReadRegister2);

  assign ReadData1 = (ReadRegister1 == ZERO_IDX) ? '0 :
                     bypass1                     ? WriteData :
                                                   stored[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == ZERO_IDX) ? '0 :
                     bypass2                     ? WriteData :
                                                   stored[ReadRegister2];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file with directed scenarios and a random model
module tb_reg_file;

  localparam int W = 64;
  localparam logic [W-1:0] STEP = 64'h0101010101010101;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   ReadRegister1, ReadRegister2, WriteRegister;
  logic [W-1:0] WriteData;
  logic         RegWrite;
  logic [W-1:0] ReadData1, ReadData2;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mdl [32];
  bit           mdl_valid = 1'b0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // Expected read value: XZR reads zero, a live write to the same address is seen
  // immediately, otherwise the architectural contents.
  function automatic logic [W-1:0] exp_read(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (RegWrite && !reset && WriteRegister == a) return WriteData;
    return mdl[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mdl_valid = 1'b1;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      mdl[WriteRegister] = WriteData;
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      checks++;
      if (ReadData1 !== exp_read(ReadRegister1)) begin
        failures++;
        $display("FAIL model_rd1 addr=%0d got=%h want=%h", ReadRegister1, ReadData1, exp_read(ReadRegister1));
      end
      checks++;
      if (ReadData2 !== exp_read(ReadRegister2)) begin
        failures++;
        $display("FAIL model_rd2 addr=%0d got=%h want=%h", ReadRegister2, ReadData2, exp_read(ReadRegister2));
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 5'd5, 64'hFF, 5'd5, 5'd0);
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd5, 5'd0);
    #1;
    check("reset_x5", ReadData1, 64'd0);
    check("reset_x0", ReadData2, 64'd0);

    drive(1'b1, 5'd3, 64'd8675309, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, '0, 5'd3, 5'd4);
    #1;
    check("basic_x3", ReadData1, 64'd8675309);
    check("basic_x4", ReadData2, 64'd0);

    drive(1'b1, 5'd31, 64'hDEAD, 5'd31, 5'd31);
    #1;
    check("xzr_wcycle_rd1", ReadData1, 64'd0);
    check("xzr_wcycle_rd2", ReadData2, 64'd0);
    step();
    RegWrite = 1'b0;
    #1;
    check("xzr_after_rd1", ReadData1, 64'd0);
    check("xzr_after_rd2", ReadData2, 64'd0);

    drive(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
    #1;
    check("bypass_pre_rd1", ReadData1, 64'h22);
    check("bypass_pre_rd2", ReadData2, 64'h22);
    step();
    RegWrite = 1'b0;
    #1;
    check("bypass_post_rd1", ReadData1, 64'h22);
    check("bypass_post_rd2", ReadData2, 64'h22);

    drive(1'b0, 5'd9, 64'hAB, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, '0, 5'd9, 5'd9);
    #1;
    check("wdis_x9", ReadData1, 64'd0);

    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), STEP * 64'(i), 5'd0, 5'd0);
      step();
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #2;
      check($sformatf("sweep_rd1_x%0d", i), ReadData1, (i == 31) ? 64'd0 : STEP * 64'(i));
      check($sformatf("sweep_rd2_x%0d", 31 - i), ReadData2, (i == 0) ? 64'd0 : STEP * 64'(31 - i));
    end

    // Reset mid-operation: bypass suppressed, stored contents visible until the edge.
    reset = 1'b1;
    drive(1'b1, 5'd10, 64'h5555, 5'd10, 5'd10);
    #1;
    check("rst_nobypass", ReadData1, STEP * 64'd10);
    step();
    check("rst_cleared", ReadData1, 64'd0);
    reset = 1'b0;
    RegWrite = 1'b0;
    step();
    check("rst_write_dropped", ReadData2, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      RegWrite      = $urandom_range(0, 2) != 0;
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = {$urandom, $urandom};
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
